weights_loader: RTL and testbench

- Sequencer placed directly downstream of the weights ROM.
- On request, it walks the ROM addresses 0..KERNEL_SIZE-1 and captures each parameter into a flat kernel register bank.
- It then presents the complete kernel to the convolution engine with a valid/ack handshake.
- The ROM is read combinationally: address and enable go out in a cycle, and data is captured at the end of that same cycle.

---
 rtl/weights_loader.sv | 155 +++++++++++++++
 tb/tb_weights_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weights_loader.sv
// weights_loader: sequencer between the weights ROM and the convolution engine.
// On request it walks ROM addresses 0..KERNEL_SIZE-1, captures every weight
// into a flat kernel register bank, then presents the whole kernel to the
// consumer with a valid/ack handshake.
//
// Optional feature macro: WEIGHTS_LOADER_CHECKSUM_EN
//   When defined, an extra output kernel_checksum carries the unsigned sum of
//   all captured weights. It is cleared on entry to LOAD and is final whenever
//   kernel_valid is high. When undefined, the port and accumulator are absent.
module weights_loader #(
  parameter int PARA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 25,
  parameter int ADDR_WIDTH  = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load_start,
  input  logic                              kernel_ack,
  output logic                              rom_r_en,
  output logic [ADDR_WIDTH-1:0]             rom_raddr,
  input  logic [PARA_WIDTH-1:0]             rom_din,
  output logic [KERNEL_SIZE*PARA_WIDTH-1:0] kernel_data,
  output logic                              kernel_valid,
  output logic                              busy
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  ,
  output logic [PARA_WIDTH+ADDR_WIDTH-1:0]  kernel_checksum
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                              r_state;
  state_t                              w_stateNext;
  logic   [ADDR_WIDTH-1:0]             r_counter;
  logic   [KERNEL_SIZE*PARA_WIDTH-1:0] r_kernelData;
  logic                                r_kernelValid;

  logic w_startLoad;
  logic w_capture;
  logic w_lastCapture;
  logic w_release;

  // State register; reset aborts any load or hold in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode plus the strobes that steer the datapath.
  always_comb begin
    w_stateNext   = r_state;
    w_startLoad   = 1'b0;
    w_capture     = 1'b0;
    w_lastCapture = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) begin
          w_startLoad = 1'b1;
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        w_capture = 1'b1;
        if (r_counter == LAST_ADDR) begin
          w_lastCapture = 1'b1;
          w_stateNext   = HOLD;
        end
      end
      HOLD: begin
        if (kernel_ack) begin
          w_release = 1'b1;
          if (load_start) begin
            w_startLoad = 1'b1;
            w_stateNext = LOAD;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Address counter; it only leaves zero while loading and wraps on the last capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
    end else if (w_startLoad || w_lastCapture) begin
      r_counter <= '0;
    end else if (w_capture) begin
      r_counter <= r_counter + 1'b1;
    end
  end

  // Kernel bank: the slot addressed by the counter takes this cycle's ROM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernelData <= '0;
    end else begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        if (w_capture && (r_counter == ADDR_WIDTH'(i))) begin
          r_kernelData[i*PARA_WIDTH +: PARA_WIDTH] <= rom_din;
        end
      end
    end
  end

  // Valid rises with the final capture and drops once the consumer acknowledges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kernelValid <= 1'b0;
    end else if (w_lastCapture) begin
      r_kernelValid <= 1'b1;
    end else if (w_release) begin
      r_kernelValid <= 1'b0;
    end
  end

`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  logic [PARA_WIDTH+ADDR_WIDTH-1:0] r_checksum;

  // Running sum of captured weights, restarted whenever a new load begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if (w_startLoad) begin
      r_checksum <= '0;
    end else if (w_capture) begin
      r_checksum <= r_checksum + {{ADDR_WIDTH{1'b0}}, rom_din};
    end
  end

  assign kernel_checksum = r_checksum;
`endif

  assign rom_r_en     = (r_state == LOAD);
  assign busy         = (r_state == LOAD);
  assign rom_raddr    = r_counter;
  assign kernel_data  = r_kernelData;
  assign kernel_valid = r_kernelValid;

endmodule

// File: tb/tb_weights_loader.sv
// tb_weights_loader: randomized scoreboard bench for weights_loader.
// Stimulus pushes the expected kernel (a snapshot of the ROM model) into a
// queue; an independent monitor pops and compares whenever valid rises.
module tb_weights_loader;

  localparam int PW = 8;
  localparam int KS = 25;
  localparam int AW = 5;
  localparam int KW = KS * PW;
  localparam int SW = PW + AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          kernel_ack = 1'b0;
  logic          rom_r_en;
  logic [AW-1:0] rom_raddr;
  logic [PW-1:0] rom_din;
  logic [KW-1:0] kernel_data;
  logic          kernel_valid;
  logic          busy;
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
  logic [SW-1:0] kernel_checksum;
`endif

  weights_loader #(
    .PARA_WIDTH (PW),
    .KERNEL_SIZE(KS),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_start     (load_start),
    .kernel_ack     (kernel_ack),
    .rom_r_en       (rom_r_en),
    .rom_raddr      (rom_raddr),
    .rom_din        (rom_din),
    .kernel_data    (kernel_data),
    .kernel_valid   (kernel_valid),
    .busy           (busy)
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    ,
    .kernel_checksum(kernel_checksum)
`endif
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Combinational ROM model.
  logic [PW-1:0] rom [32];
  always_comb rom_din = rom[rom_raddr];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [KW-1:0] data;
    logic [SW-1:0] sum;
    int            cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;

  task automatic checkOutput(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: a full load copies ROM words 0..KS-1; valid appears KS+1 cycles
  // after the cycle in which the request is driven.
  function automatic exp_t modelKernel(int startCyc);
    exp_t e;
    int   s;
    s = 0;
    for (int i = 0; i < KS; i++) begin
      e.data[i*PW +: PW] = rom[i];
      s += int'(rom[i]);
    end
    e.sum = SW'(s);
    e.cyc = startCyc + KS + 1;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomRom();
    for (int i = 0; i < 32; i++) rom[i] = PW'($urandom);
  endtask

  task automatic issueLoad(bit withAck);
    lastExp = modelKernel(cycleCnt);
    expQ.push_back(lastExp);
    load_start = 1'b1;
    kernel_ack = withAck;
    tick();
    load_start = 1'b0;
    kernel_ack = 1'b0;
  endtask

  task automatic waitValid(string name);
    int n;
    n = 0;
    while (!kernel_valid && n < 100) begin
      tick();
      n++;
    end
    checkOutput({name, "_valid_seen"}, kernel_valid, 1);
  endtask

  task automatic ackKernel();
    kernel_ack = 1'b1;
    tick();
    kernel_ack = 1'b0;
    checkOutput("valid_after_ack", kernel_valid, 0);
  endtask

  // Monitor: address sequencing, idle invariants and scoreboard pops.
  initial begin
    logic prevValid;
    logic prevEn;
    int   expAddr;
    int   lastRun;
    exp_t e;
    prevValid = 1'b0;
    prevEn    = 1'b0;
    expAddr   = 0;
    lastRun   = 0;
    forever begin
      @(negedge clk);
      checkOutput("busy_eq_ren", busy, rom_r_en);
      if (rom_r_en) begin
        if (!prevEn) begin
          checks++;
          if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL spurious_load: got rom_r_en 1, required 0 at cycle %0d", cycleCnt);
          end
        end
        checkOutput("raddr_seq", rom_raddr, expAddr);
        expAddr++;
      end else begin
        checkOutput("raddr_idle", rom_raddr, 0);
        if (expAddr != 0) begin
          lastRun = expAddr;
          expAddr = 0;
        end
      end
      if (kernel_valid && !prevValid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_valid: got valid 1, required 0 at cycle %0d", cycleCnt);
        end else begin
          e = expQ.pop_front();
          checkOutput("valid_latency", cycleCnt, e.cyc);
          checkOutput("kernel_data", kernel_data, e.data);
          checkOutput("load_length", lastRun, KS);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
          checkOutput("checksum", kernel_checksum, e.sum);
`endif
        end
      end
      prevValid = kernel_valid;
      prevEn    = rom_r_en;
    end
  end

  // Stimulus.
  initial begin
    bit            inHold;
    int            n;
    logic [KW-1:0] snapshot;

    for (int i = 0; i < 32; i++) rom[i] = PW'(i + 1);

    // Reset and idle.
    #13;
    checkOutput("rst_ren", rom_r_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_raddr", rom_raddr, 0);
    checkOutput("rst_valid", kernel_valid, 0);
    checkOutput("rst_data", kernel_data, 0);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    checkOutput("rst_checksum", kernel_checksum, 0);
`endif
    #4 rst_n = 1'b1;
    repeat (10) begin
      tick();
      checkOutput("idle_ren", rom_r_en, 0);
    end
    checkOutput("idle_data", kernel_data, 0);

    // Single load with ROM word i = i+1.
    issueLoad(1'b0);
    waitValid("single");
    checkOutput("slot0", kernel_data[7:0], 8'h01);
    checkOutput("slot24", kernel_data[24*PW +: PW], 8'h19);
`ifdef WEIGHTS_LOADER_CHECKSUM_EN
    checkOutput("checksum325", kernel_checksum, 325);
`endif
    ackKernel();

    // Requests during LOAD and during HOLD without ack are ignored.
    randomRom();
    issueLoad(1'b0);
    repeat (9) tick();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checkOutput("ignore_busy", busy, 1);
    waitValid("ignore");
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    repeat (3) tick();
    checkOutput("hold_ignore_valid", kernel_valid, 1);
    checkOutput("hold_ignore_ren", rom_r_en, 0);
    ackKernel();
    repeat (30) begin
      tick();
      checkOutput("no_second_load", rom_r_en, 0);
    end

    // Back-to-back reload: ack and start in the same cycle.
    randomRom();
    issueLoad(1'b0);
    waitValid("b2b_first");
    randomRom();
    issueLoad(1'b1);
    checkOutput("b2b_valid_low", kernel_valid, 0);
    checkOutput("b2b_ren", rom_r_en, 1);
    checkOutput("b2b_raddr0", rom_raddr, 0);
    waitValid("b2b_second");

    // Hold stability while the ROM changes underneath.
    snapshot = lastExp.data;
    randomRom();
    repeat (50) begin
      tick();
      checkOutput("hold_valid", kernel_valid, 1);
    end
    checkOutput("hold_data", kernel_data, snapshot);
    ackKernel();

    // Asynchronous reset in the middle of a load.
    randomRom();
    issueLoad(1'b0);
    n = 0;
    while (rom_raddr != AW'(12) && n < 40) begin
      tick();
      n++;
    end
    checkOutput("midreset_reach12", rom_raddr, 12);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("midreset_ren", rom_r_en, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_data", kernel_data, 0);
    checkOutput("midreset_valid", kernel_valid, 0);
    checkOutput("midreset_raddr", rom_raddr, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("postreset_data", kernel_data, 0);
    issueLoad(1'b0);
    waitValid("postreset");
    ackKernel();

    // Randomized sequence of loads, holds and reloads.
    inHold = 1'b0;
    repeat (6) begin
      randomRom();
      if (!inHold) begin
        repeat ($urandom_range(0, 4)) tick();
        issueLoad(1'b0);
      end else begin
        issueLoad(1'b1);
        checkOutput("rand_b2b_valid_low", kernel_valid, 0);
      end
      waitValid("rand");
      inHold = 1'b1;
      repeat ($urandom_range(0, 5)) tick();
      if ($urandom_range(0, 1) == 1) begin
        ackKernel();
        inHold = 1'b0;
      end
    end
    if (inHold) ackKernel();

    repeat (5) tick();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
